// File: rtl/pipeline_job_scheduler.sv
// pipeline_job_scheduler
//   Sequences whole jobs (one top + N bots) into the Dedekind pipeline wrapper.
//   Each job loads its top with a start-new-top beat. It then streams N bots,
//   limited by an outstanding-result credit. It accumulates the N results and
//   presents one per-job total.
// Ports
//   clock, rst                      clock, synchronous active-high reset
//   i_job_valid/o_job_ready         job descriptor handshake (i_job_top, i_job_bot_count)
//   i_bot_valid/o_bot_ready         bot feed handshake (i_bot_data)
//   o_pipe_valid/i_pipe_ready       beat to pipeline (o_pipe_start_new_top, o_pipe_data)
//   i_res_valid/o_res_ready         pipeline result ([40:38] pcoeff, [37:0] summed data)
//   o_out_valid/i_out_ready         job total (o_out_sum, o_out_pcoeff, o_out_count)
//   o_err_unexpected                sticky: result seen with nothing outstanding
//
// state    | meaning
// IDLE     | waiting for a job descriptor
// LOAD_TOP | offering the top beat to the pipeline
// STREAM   | passing bots through, credit-limited
// DRAIN    | all bots sent, collecting remaining results
// EMIT     | job total presented
module pipeline_job_scheduler #(
  parameter int CNT_W        = 32,
  parameter int MAX_INFLIGHT = 64,
  parameter int SUM_W        = 64
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               i_job_valid,
  output logic               o_job_ready,
  input  logic [127:0]       i_job_top,
  input  logic [CNT_W-1:0]   i_job_bot_count,
  input  logic               i_bot_valid,
  output logic               o_bot_ready,
  input  logic [127:0]       i_bot_data,
  output logic               o_pipe_valid,
  input  logic               i_pipe_ready,
  output logic               o_pipe_start_new_top,
  output logic [127:0]       o_pipe_data,
  input  logic               i_res_valid,
  output logic               o_res_ready,
  input  logic [40:0]        i_res_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [SUM_W-1:0]   o_out_sum,
  output logic [CNT_W+2:0]   o_out_pcoeff,
  output logic [CNT_W-1:0]   o_out_count,
  output logic               o_err_unexpected
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_TOP, S_STREAM, S_DRAIN, S_EMIT} state_t;

  state_t             r_state;
  logic [127:0]       r_top;
  logic [CNT_W-1:0]   r_n;
  logic [CNT_W-1:0]   r_sent;
  logic [CNT_W-1:0]   r_count;
  logic [SUM_W-1:0]   r_sum;
  logic [CNT_W+2:0]   r_pcoeff;
  logic               r_err;

  logic [CNT_W-1:0]   w_inflight;
  logic               w_in_stream;
  logic               w_credit;
  logic               w_go;
  logic               w_res_err;
  logic               w_res_acc;
  logic               w_last_res;

  assign w_inflight  = r_sent - r_count;
  assign w_in_stream = (r_state == S_STREAM);
  // Credit is judged on registered counters, so a result freed this cycle
  // only opens the gate on the next one.
  assign w_credit    = (r_sent != r_n) && (w_inflight < LP_MAX);
  assign w_go        = w_in_stream && i_bot_valid && i_pipe_ready && w_credit;
  // Any result with nothing outstanding is flagged, whether or not it is accepted.
  assign w_res_err   = i_res_valid && (w_inflight == '0);
  assign w_res_acc   = i_res_valid && o_res_ready && (w_inflight != '0);
  assign w_last_res  = w_res_acc && ((r_count + CNT_W'(1)) == r_n);

  assign o_job_ready          = (r_state == S_IDLE);
  assign o_pipe_valid         = (r_state == S_LOAD_TOP) || (w_in_stream && i_bot_valid && w_credit);
  assign o_pipe_start_new_top = (r_state == S_LOAD_TOP);
  assign o_pipe_data          = (r_state == S_LOAD_TOP) ? r_top :
                                (w_in_stream ? i_bot_data : '0);
  assign o_bot_ready          = w_in_stream && i_pipe_ready && w_credit;
  assign o_res_ready          = w_in_stream || (r_state == S_DRAIN);
  assign o_out_valid          = (r_state == S_EMIT);
  assign o_out_sum            = r_sum;
  assign o_out_pcoeff         = r_pcoeff;
  assign o_out_count          = r_count;
  assign o_err_unexpected     = r_err;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_top    <= '0;
      r_n      <= '0;
      r_sent   <= '0;
      r_count  <= '0;
      r_sum    <= '0;
      r_pcoeff <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_res_err) r_err <= 1'b1;
      if (w_res_acc) begin
        r_sum    <= r_sum + SUM_W'(i_res_data[37:0]);
        r_pcoeff <= r_pcoeff + (CNT_W+3)'(i_res_data[40:38]);
        r_count  <= r_count + CNT_W'(1);
      end
      if (w_go) r_sent <= r_sent + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (i_job_valid) begin
            r_top    <= i_job_top;
            r_n      <= i_job_bot_count;
            r_sum    <= '0;
            r_pcoeff <= '0;
            r_count  <= '0;
            r_sent   <= '0;
            // Zero-bot jobs spend one cycle in DRAIN (count==N already) so the
            // pipeline is never touched.
            r_state  <= (i_job_bot_count == '0) ? S_DRAIN : S_LOAD_TOP;
          end
        end
        S_LOAD_TOP: if (i_pipe_ready) r_state <= S_STREAM;
        S_STREAM:   if (w_go && ((r_sent + CNT_W'(1)) == r_n)) r_state <= S_DRAIN;
        // The last result moves straight to EMIT so the total appears the next cycle.
        S_DRAIN:    if ((r_count == r_n) || w_last_res) r_state <= S_EMIT;
        S_EMIT:     if (i_out_ready) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_job_scheduler.sv
// tb_pipeline_job_scheduler
//   Bench for pipeline_job_scheduler (MAX_INFLIGHT=2). A table drives the
//   STREAM handshakes. Hand sequences cover zero-bot jobs, credit release, the
//   error flag and mid-job reset. Random jobs are checked against a
//   transaction-level model: beat order, credit bound and summed totals.
module tb_pipeline_job_scheduler;
  localparam int TB_MAX = 2;

  logic         clock = 1'b0;
  logic         rst;
  logic         i_job_valid;
  logic         o_job_ready;
  logic [127:0] i_job_top;
  logic [31:0]  i_job_bot_count;
  logic         i_bot_valid;
  logic         o_bot_ready;
  logic [127:0] i_bot_data;
  logic         o_pipe_valid;
  logic         i_pipe_ready;
  logic         o_pipe_start_new_top;
  logic [127:0] o_pipe_data;
  logic         i_res_valid;
  logic         o_res_ready;
  logic [40:0]  i_res_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [63:0]  o_out_sum;
  logic [34:0]  o_out_pcoeff;
  logic [31:0]  o_out_count;
  logic         o_err_unexpected;

  pipeline_job_scheduler #(.CNT_W(32), .MAX_INFLIGHT(TB_MAX), .SUM_W(64)) dut (
    .clock(clock), .rst(rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_top(i_job_top), .i_job_bot_count(i_job_bot_count),
    .i_bot_valid(i_bot_valid), .o_bot_ready(o_bot_ready), .i_bot_data(i_bot_data),
    .o_pipe_valid(o_pipe_valid), .i_pipe_ready(i_pipe_ready),
    .o_pipe_start_new_top(o_pipe_start_new_top), .o_pipe_data(o_pipe_data),
    .i_res_valid(i_res_valid), .o_res_ready(o_res_ready), .i_res_data(i_res_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_sum(o_out_sum), .o_out_pcoeff(o_out_pcoeff), .o_out_count(o_out_count),
    .o_err_unexpected(o_err_unexpected)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [40:0] res_vals[16];

  typedef struct {
    logic bv;
    logic pr;
    logic pv;
    logic br;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one job end to end. rnd=0: all partners always ready/valid.
  // Results returned are res_vals[0..], issued in bot order.
  task automatic run_job(input logic [127:0] top, input int n, input bit rnd,
                         output logic [63:0] got_sum, output logic [34:0] got_pc,
                         output logic [31:0] got_cnt, output int tops, output int bots);
    logic [127:0] bot_vals[16];
    logic [63:0]  exp_sum = '0;
    logic [34:0]  exp_pc = '0;
    logic [31:0]  exp_cnt = '0;
    int bi = 0, ri = 0, sent = 0, answered = 0, cyc = 0;
    bit done = 0, seen_out = 0;
    bit ja, pb, ba, ra, oa;
    got_sum = '0; got_pc = '0; got_cnt = '0; tops = 0; bots = 0;
    for (int i = 0; i < 16; i++) bot_vals[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    i_job_valid = 1'b1;
    i_job_top = top;
    i_job_bot_count = 32'(n);
    while (!done && cyc < 3000) begin
      if (!i_bot_valid && bi < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        i_bot_valid = 1'b1;
        i_bot_data = bot_vals[bi];
      end
      i_pipe_ready = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      if (!i_res_valid && ri < sent && (!rnd || $urandom_range(0, 1) != 0)) begin
        i_res_valid = 1'b1;
        i_res_data = res_vals[ri];
        ri++;
      end
      i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      ja = i_job_valid && o_job_ready;
      pb = o_pipe_valid && i_pipe_ready;
      ba = i_bot_valid && o_bot_ready;
      ra = i_res_valid && o_res_ready;
      oa = o_out_valid && i_out_ready;
      if (pb && o_pipe_start_new_top) begin
        tops++;
        chk("top_beat_data", o_pipe_data, top);
        chk("top_before_bots", 128'(bots), 128'd0);
      end else if (pb) begin
        if (bots < n) chk("bot_beat_data", o_pipe_data, bot_vals[bots]);
        else chk("extra_bot_beat", 128'(bots + 1), 128'(n));
        bots++;
      end
      if ((pb && !o_pipe_start_new_top) || ba)
        chk("bot_pass_through", {126'd0, pb && !o_pipe_start_new_top, ba}, 128'd3);
      if (ba) begin
        chk("inflight_limit", 128'(sent - answered < TB_MAX), 128'd1);
        sent++;
        bi++;
      end
      if (ra) begin
        exp_sum += 64'(i_res_data[37:0]);
        exp_pc += 35'(i_res_data[40:38]);
        exp_cnt++;
        answered++;
      end
      if (o_out_valid) begin
        if (!seen_out) begin
          chk("total_sum", o_out_sum, exp_sum);
          chk("total_pcoeff", o_out_pcoeff, exp_pc);
          chk("total_count", o_out_count, 128'(n));
          got_sum = o_out_sum; got_pc = o_out_pcoeff; got_cnt = o_out_count;
          seen_out = 1;
        end else begin
          chk("total_stable", {o_out_sum, o_out_pcoeff, o_out_count},
              {got_sum, got_pc, got_cnt});
        end
        if (oa) done = 1;
      end
      tick();
      if (ja) i_job_valid = 1'b0;
      if (ba) i_bot_valid = 1'b0;
      if (ra) i_res_valid = 1'b0;
      cyc++;
    end
    if (!done) chk("job_timeout", 128'd0, 128'd1);
    chk("job_top_beats", 128'(tops), (n > 0) ? 128'd1 : 128'd0);
    chk("job_bot_beats", 128'(bots), 128'(n));
    i_job_valid = 1'b0;
    i_bot_valid = 1'b0;
    i_res_valid = 1'b0;
    i_pipe_ready = 1'b0;
    i_out_ready = 1'b0;
  endtask

  logic [63:0] g_sum;
  logic [34:0] g_pc;
  logic [31:0] g_cnt;
  int g_tops, g_bots;

  initial begin
    int k;
    tbl[0] = '{bv: 1'b0, pr: 1'b0, pv: 1'b0, br: 1'b0};
    tbl[1] = '{bv: 1'b0, pr: 1'b1, pv: 1'b0, br: 1'b1};
    tbl[2] = '{bv: 1'b1, pr: 1'b0, pv: 1'b1, br: 1'b0};
    tbl[3] = '{bv: 1'b1, pr: 1'b1, pv: 1'b1, br: 1'b1};
    tbl[4] = '{bv: 1'b1, pr: 1'b0, pv: 1'b1, br: 1'b0};
    tbl[5] = '{bv: 1'b1, pr: 1'b1, pv: 1'b1, br: 1'b1};
    tbl[6] = '{bv: 1'b1, pr: 1'b1, pv: 1'b0, br: 1'b0};
    tbl[7] = '{bv: 1'b0, pr: 1'b1, pv: 1'b0, br: 1'b0};

    rst = 1'b1;
    i_job_valid = 1'b0; i_job_top = '0; i_job_bot_count = '0;
    i_bot_valid = 1'b0; i_bot_data = '0; i_pipe_ready = 1'b0;
    i_res_valid = 1'b0; i_res_data = '0; i_out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_job_ready", 128'(o_job_ready), 128'd1);
    chk("reset_pipe_valid", 128'(o_pipe_valid), 128'd0);
    chk("reset_out_valid", 128'(o_out_valid), 128'd0);
    chk("reset_res_ready", 128'(o_res_ready), 128'd0);
    chk("reset_err", 128'(o_err_unexpected), 128'd0);
    chk("reset_totals", {o_out_sum, o_out_pcoeff, o_out_count}, 128'd0);
    tick();

    // N=3, results 5,7,9 with pcoeff 1,2,3
    res_vals[0] = {3'd1, 38'd5};
    res_vals[1] = {3'd2, 38'd7};
    res_vals[2] = {3'd3, 38'd9};
    run_job(128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 3, 1'b0, g_sum, g_pc, g_cnt, g_tops, g_bots);
    chk("t1_sum", g_sum, 128'd21);
    chk("t1_pcoeff", g_pc, 128'd6);
    chk("t1_count", g_cnt, 128'd3);
    #1;
    chk("t1_job_ready_after", 128'(o_job_ready), 128'd1);
    tick();

    // N=0: pipeline untouched, total two cycles after accept
    i_job_valid = 1'b1; i_job_bot_count = 32'd0; i_job_top = 128'h77;
    i_bot_valid = 1'b1; i_pipe_ready = 1'b1;
    #1;
    chk("t2_job_ready", 128'(o_job_ready), 128'd1);
    tick();
    i_job_valid = 1'b0;
    #1;
    chk("t2_no_pipe_c1", 128'(o_pipe_valid), 128'd0);
    chk("t2_out_valid_c1", 128'(o_out_valid), 128'd0);
    tick();
    #1;
    chk("t2_no_pipe_c2", 128'(o_pipe_valid), 128'd0);
    chk("t2_out_valid_c2", 128'(o_out_valid), 128'd1);
    chk("t2_out_sum", o_out_sum, 128'd0);
    chk("t2_out_count", o_out_count, 128'd0);
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0; i_bot_valid = 1'b0; i_pipe_ready = 1'b0;
    #1;
    chk("t2_job_ready_after", 128'(o_job_ready), 128'd1);
    tick();

    // STREAM handshake table, N=3 with two credits
    i_job_valid = 1'b1; i_job_bot_count = 32'd3; i_job_top = 128'hC0DE;
    tick();
    i_job_valid = 1'b0; i_pipe_ready = 1'b1;
    #1;
    chk("t3_top_flag", 128'(o_pipe_start_new_top), 128'd1);
    chk("t3_top_data", o_pipe_data, 128'hC0DE);
    tick();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      i_bot_valid = tbl[i].bv;
      i_pipe_ready = tbl[i].pr;
      i_bot_data = 128'hB0 + 128'(k);
      #1;
      chk($sformatf("tbl%0d_pipe_valid", i), 128'(o_pipe_valid), 128'(tbl[i].pv));
      chk($sformatf("tbl%0d_bot_ready", i), 128'(o_bot_ready), 128'(tbl[i].br));
      if (tbl[i].pv) chk($sformatf("tbl%0d_data", i), o_pipe_data, i_bot_data);
      if (i_bot_valid && o_bot_ready) k++;
      tick();
    end
    chk("t3_sent_before_block", 128'(k), 128'd2);
    i_bot_valid = 1'b1; i_bot_data = 128'hB0 + 128'(k); i_pipe_ready = 1'b1;
    i_res_valid = 1'b1; i_res_data = {3'd1, 38'd10};
    #1;
    chk("t3_credit_same_cycle", 128'(o_bot_ready), 128'd0);
    tick();
    i_res_valid = 1'b0;
    #1;
    chk("t3_credit_freed", 128'(o_bot_ready), 128'd1);
    tick();
    #1;
    chk("t3_drain_no_bot", 128'(o_bot_ready), 128'd0);
    i_bot_valid = 1'b0;
    i_res_valid = 1'b1; i_res_data = {3'd2, 38'd20};
    tick();
    i_res_data = {3'd3, 38'd30};
    #1;
    chk("t3_out_valid_early", 128'(o_out_valid), 128'd0);
    tick();
    i_res_valid = 1'b0;
    #1;
    chk("t3_out_valid", 128'(o_out_valid), 128'd1);
    chk("t3_out_sum", o_out_sum, 128'd60);
    chk("t3_out_pcoeff", o_out_pcoeff, 128'd6);
    chk("t3_out_count", o_out_count, 128'd3);
    chk("t3_err_clear", 128'(o_err_unexpected), 128'd0);
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0; i_pipe_ready = 1'b0;
    tick();

    // Stray result in IDLE
    i_res_valid = 1'b1; i_res_data = {3'd7, 38'h3F_FFFF_FFFF};
    #1;
    chk("t5_res_ready_idle", 128'(o_res_ready), 128'd0);
    tick();
    i_res_valid = 1'b0;
    #1;
    chk("t5_err_set", 128'(o_err_unexpected), 128'd1);
    tick();
    res_vals[0] = {3'd0, 38'd100};
    res_vals[1] = {3'd7, 38'd1};
    run_job(128'h5EED, 2, 1'b0, g_sum, g_pc, g_cnt, g_tops, g_bots);
    chk("t5_sum", g_sum, 128'd101);
    chk("t5_pcoeff", g_pc, 128'd7);
    chk("t5_count", g_cnt, 128'd2);
    chk("t5_err_sticky", 128'(o_err_unexpected), 128'd1);

    // Reset in STREAM after 2 of 4 bots
    i_job_valid = 1'b1; i_job_bot_count = 32'd4; i_job_top = 128'hDEAD;
    tick();
    i_job_valid = 1'b0; i_pipe_ready = 1'b1; i_bot_valid = 1'b1; i_bot_data = 128'h1;
    tick();
    i_bot_data = 128'h2;
    tick();
    i_bot_data = 128'h3;
    tick();
    rst = 1'b1; i_bot_valid = 1'b0; i_pipe_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_job_ready", 128'(o_job_ready), 128'd1);
    chk("t6_pipe_valid", 128'(o_pipe_valid), 128'd0);
    chk("t6_pipe_start", 128'(o_pipe_start_new_top), 128'd0);
    chk("t6_pipe_data", o_pipe_data, 128'd0);
    chk("t6_bot_ready", 128'(o_bot_ready), 128'd0);
    chk("t6_res_ready", 128'(o_res_ready), 128'd0);
    chk("t6_out_valid", 128'(o_out_valid), 128'd0);
    chk("t6_totals", {o_out_sum, o_out_pcoeff, o_out_count}, 128'd0);
    chk("t6_err", 128'(o_err_unexpected), 128'd0);
    tick();
    res_vals[0] = {3'd5, 38'd123};
    run_job(128'hFACE, 1, 1'b0, g_sum, g_pc, g_cnt, g_tops, g_bots);
    chk("t6_sum", g_sum, 128'd123);
    chk("t6_pcoeff", g_pc, 128'd5);
    chk("t6_count", g_cnt, 128'd1);

    // Random jobs with random handshake timing
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 16; i++) res_vals[i] = 41'({$urandom(), $urandom()});
      run_job({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom_range(0, 12), 1'b1,
              g_sum, g_pc, g_cnt, g_tops, g_bots);
      if ($urandom_range(0, 2) == 0) tick();
    end
    #1;
    chk("final_err_clear", 128'(o_err_unexpected), 128'd0);
    chk("final_idle", 128'(o_job_ready), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
